// File: rtl/seq_pkg.sv
// Shared definitions for the sequence serializer and the detector it feeds.
package seq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } seq_state_t;

  localparam int         SEQ_WIDTH   = 4;
  localparam logic [3:0] SEQ_PATTERN = 4'b1101;

endpackage

// File: rtl/seq_word_buffer.sv
// Single-entry hold register between the word source and the shifter.
// Latency: a word is visible in hold the cycle after it is accepted.
// Backpressure: data_ready = ~hold_full; the source holds its word until it is taken.
module seq_word_buffer
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             pop,
  output logic             data_ready,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full
);

  assign data_ready = ~hold_full;

  // Push and pop never coincide: push needs an empty hold, pop needs a full one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (data_valid && data_ready) begin
      hold      <= data_in;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the sequence detector; MSB first, LSB first with SEQ_SERIALIZER_LSB_FIRST_EN.
// Latency: first seq_valid two edges after the accept edge; gapless when the hold is refilled in time.
// Backpressure: data_ready low while the hold is full; enable low freezes shifting without loss.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic             enable,
  output logic             seq,
  output logic             seq_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int CNT_W = $clog2(WIDTH);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             out_bit;
  logic             last_bit;
  logic             pop;

`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
  assign out_bit   = sreg[0];
  assign sreg_next = sreg >> 1;
`else
  assign out_bit   = sreg[WIDTH-1];
  assign sreg_next = sreg << 1;
`endif

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign pop      = enable & hold_full & ((state == ST_IDLE) | ((state == ST_SHIFT) & last_bit));
  assign busy     = (state == ST_SHIFT) | hold_full;

  seq_word_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .pop        (pop),
    .data_ready (data_ready),
    .hold       (hold),
    .hold_full  (hold_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      sreg      <= '0;
      seq       <= 1'b0;
      seq_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        ST_IDLE: begin
          seq_valid <= 1'b0;
          if (pop) begin
            sreg  <= hold;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (enable) begin
            seq       <= out_bit;
            seq_valid <= 1'b1;
            if (last_bit) begin
              cnt <= '0;
              // A waiting word is loaded on the final-bit edge so the next bit follows directly.
              if (hold_full) begin
                sreg <= hold;
              end else begin
                sreg     <= sreg_next;
                state    <= ST_IDLE;
                underrun <= 1'b1;
              end
            end else begin
              sreg <= sreg_next;
              cnt  <= cnt + 1'b1;
            end
          end else begin
            seq_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer; expected bit order follows SEQ_SERIALIZER_LSB_FIRST_EN.
module tb_seq_serializer;

  logic       clk;
  logic       reset;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       enable;
  logic       seq;
  logic       seq_valid;
  logic       busy;
  logic       underrun;

  int errors = 0;
  int checks = 0;

  seq_serializer #(.WIDTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .enable     (enable),
    .seq        (seq),
    .seq_valid  (seq_valid),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [3:0] w, input int i);
`ifdef SEQ_SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[3-i];
`endif
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Accept one word with nothing following, then check load, 4 bits, underrun and busy.
  task automatic single_word(input string tag, input logic [3:0] w);
    data_in    = w;
    data_valid = 1'b1;
    tick();
    chk({tag, "_acc_ready"}, {7'd0, data_ready}, 8'd0);
    chk({tag, "_acc_busy"},  {7'd0, busy},       8'd1);
    data_valid = 1'b0;
    tick();
    chk({tag, "_load_vld"},   {7'd0, seq_valid},  8'd0);
    chk({tag, "_load_ready"}, {7'd0, data_ready}, 8'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_vld"}, {7'd0, seq_valid}, 8'd1);
      chk({tag, "_bit"}, {7'd0, seq},       {7'd0, exp_bit(w, i)});
      chk({tag, "_und"}, {7'd0, underrun},  {7'd0, (i == 3)});
      chk({tag, "_busy"}, {7'd0, busy},     {7'd0, (i != 3)});
    end
    tick();
    chk({tag, "_end_vld"}, {7'd0, seq_valid}, 8'd0);
    chk({tag, "_end_und"}, {7'd0, underrun},  8'd0);
  endtask

  // Eight gapless bits of w1 then w2, with w2 captured into hold on the first of these edges.
  task automatic stream_two(input string tag, input logic [3:0] w1, input logic [3:0] w2);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) data_valid = 1'b0;
      chk({tag, "_vld"},   {7'd0, seq_valid},  8'd1);
      chk({tag, "_bit"},   {7'd0, seq},        {7'd0, (k < 4) ? exp_bit(w1, k) : exp_bit(w2, k - 4)});
      chk({tag, "_und"},   {7'd0, underrun},   {7'd0, (k == 7)});
      chk({tag, "_ready"}, {7'd0, data_ready}, {7'd0, (k >= 3)});
    end
    tick();
    chk({tag, "_end_vld"},  {7'd0, seq_valid}, 8'd0);
    chk({tag, "_end_busy"}, {7'd0, busy},      8'd0);
  endtask

  initial begin
    reset      = 1'b1;
    data_in    = 4'b0000;
    data_valid = 1'b0;
    enable     = 1'b1;
    #2;
    chk("rst_seq",   {7'd0, seq},        8'd0);
    chk("rst_vld",   {7'd0, seq_valid},  8'd0);
    chk("rst_und",   {7'd0, underrun},   8'd0);
    chk("rst_busy",  {7'd0, busy},       8'd0);
    chk("rst_ready", {7'd0, data_ready}, 8'd1);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single word, latency and underrun placement
    single_word("t1", 4'b1101);

    // Back-to-back words with data_valid held
    data_in    = 4'b1101;
    data_valid = 1'b1;
    tick();
    chk("t2_acc_ready", {7'd0, data_ready}, 8'd0);
    data_in = 4'b0110;
    tick();
    chk("t2_load_ready", {7'd0, data_ready}, 8'd1);
    stream_two("t2", 4'b1101, 4'b0110);

    // Pause for 3 cycles after the second bit
    data_in    = 4'b1101;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    chk("t3_b0", {7'd0, seq}, {7'd0, exp_bit(4'b1101, 0)});
    tick();
    chk("t3_b1", {7'd0, seq}, {7'd0, exp_bit(4'b1101, 1)});
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_pause_vld",  {7'd0, seq_valid}, 8'd0);
      chk("t3_pause_seq",  {7'd0, seq},       {7'd0, exp_bit(4'b1101, 1)});
      chk("t3_pause_busy", {7'd0, busy},      8'd1);
      chk("t3_pause_und",  {7'd0, underrun},  8'd0);
    end
    enable = 1'b1;
    tick();
    chk("t3_b2_vld", {7'd0, seq_valid}, 8'd1);
    chk("t3_b2",     {7'd0, seq},       {7'd0, exp_bit(4'b1101, 2)});
    chk("t3_b2_und", {7'd0, underrun},  8'd0);
    tick();
    chk("t3_b3_vld", {7'd0, seq_valid}, 8'd1);
    chk("t3_b3",     {7'd0, seq},       {7'd0, exp_bit(4'b1101, 3)});
    chk("t3_b3_und", {7'd0, underrun},  8'd1);
    tick();
    chk("t3_end_vld", {7'd0, seq_valid}, 8'd0);

    // Asynchronous reset in the middle of a word
    data_in    = 4'b1101;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_pre_vld", {7'd0, seq_valid}, 8'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_rst_vld",   {7'd0, seq_valid},  8'd0);
    chk("t4_rst_seq",   {7'd0, seq},        8'd0);
    chk("t4_rst_busy",  {7'd0, busy},       8'd0);
    chk("t4_rst_und",   {7'd0, underrun},   8'd0);
    chk("t4_rst_ready", {7'd0, data_ready}, 8'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("t4_post_vld", {7'd0, seq_valid}, 8'd0);
    single_word("t4", 4'b1011);

    // Word offered while hold is full must wait, not overwrite
    enable     = 1'b0;
    data_in    = 4'b1101;
    data_valid = 1'b1;
    tick();
    data_in = 4'b0110;
    tick();
    chk("t5_wait_ready", {7'd0, data_ready}, 8'd0);
    tick();
    chk("t5_wait_vld",   {7'd0, seq_valid},  8'd0);
    chk("t5_wait_busy",  {7'd0, busy},       8'd1);
    enable = 1'b1;
    tick();
    chk("t5_load_ready", {7'd0, data_ready}, 8'd1);
    chk("t5_load_vld",   {7'd0, seq_valid},  8'd0);
    stream_two("t5", 4'b1101, 4'b0110);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_serializer.md
Name: seq_serializer

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts WIDTH-bit parallel words over a valid/ready handshake and shifts them out one bit per clock on seq/seq_valid. This is the detector's seq input stream.
- A single-entry hold register double-buffers the shift register, so back-to-back words stream gap-free.

Parameters:
WIDTH, 4, bits per parallel word; WIDTH >= 2. The default matches the detector's 4-bit target sequence.
CNT_W, $clog2(WIDTH), localparam; width of the bit counter.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  parallel word to serialize
data_valid  input  1  data_in is valid
data_ready  output  1  hold register empty; equals ~hold_full
enable  input  1  shift enable; low = pause/freeze
seq  output  1  serial bit, registered
seq_valid  output  1  seq carries a live bit this cycle, registered
busy  output  1  (state == SHIFT) | hold_full
underrun  output  1  one-cycle pulse, registered; stream ran dry after a word

Behaviour:
- Reset (async, active-high): state = IDLE, hold_full = 0, counter = 0, shift register = 0.
  - Outputs: seq = 0, seq_valid = 0, underrun = 0, busy = 0, data_ready = 1.
  - A word partly shifted when reset asserts is discarded. No bits are emitted after reset.
- Accept: on an edge with data_valid & data_ready, data_in -> hold and hold_full <= 1.
  - data_in is ignored when data_ready = 0. The source holds its word until accepted.
  - Accepting is independent of enable.
- States:
  - IDLE:
    - seq_valid <= 0, seq keeps its last value.
    - If enable & hold_full: shift register <= hold, hold_full <= 0, counter <= 0, go to SHIFT.
  - SHIFT, enable = 1, each edge:
    - seq <= sreg[WIDTH-1], seq_valid <= 1, sreg <= sreg << 1, counter <= counter + 1.
    - When counter == WIDTH-1, the current bit is the last one:
      - If hold_full: reload sreg from hold, clear hold_full, counter <= 0, stay in SHIFT. Output is gapless.
      - Else: go to IDLE and underrun <= 1 for exactly one cycle, coincident with the final bit on seq.
  - SHIFT, enable = 0:
    - sreg, counter and state are frozen. seq_valid <= 0, seq holds its value.
    - No bit is lost or duplicated on resume.
- Latency: with enable high, the first seq_valid is 2 edges after the accept edge (accept -> load -> first bit).
- Bit order: MSB first.
- Hold freeing and acceptance:
  - A reload and a new accept cannot occur on the same edge, because ready = ~hold_full.
  - Hold freed at an edge -> data_ready = 1 in the following cycle.
- underrun is not raised from IDLE and is never raised twice per word.
- Throughput: one WIDTH-bit word per WIDTH cycles sustained.

Optional Feature:
- Macro: SEQ_SERIALIZER_LSB_FIRST_EN.
- Defined: bits are emitted LSB first. The register shifts right, seq = sreg[0].
- Undefined: MSB first as above.
- Handshake, latency and underrun timing are identical in both builds.

Decomposition:
- Shared package seq_pkg:
  - State typedef: enum ST_IDLE, ST_SHIFT.
  - Default SEQ_WIDTH = 4.
  - Target pattern constant SEQ_PATTERN = 4'b1101, shared with the detector and its bench.
- One natural sub-module, seq_word_buffer: a single-entry valid/ready hold register (hold, hold_full, data_ready, pop input).
- The FSM, counter and shifter stay in seq_serializer.

Test Plan:
1. Reset, enable = 1, one word 4'b1101 accepted at edge E:
   - seq_valid high for edges E+2..E+5, with seq = 1,1,0,1.
   - underrun high only in the E+5 cycle; busy falls after E+5.
2. Words 4'b1101 then 4'b0110 presented back-to-back with data_valid held:
   - 8 contiguous valid bits 1,1,0,1,0,1,1,0.
   - No underrun between words; data_ready low while the second word waits in hold.
3. enable driven low for 3 cycles after the 2nd bit of 4'b1101:
   - seq_valid low for those 3 cycles.
   - Bits resume 0,1 with no loss or duplication.
4. reset asserted mid-word (after 2 bits):
   - seq_valid, seq, busy and underrun go to 0 immediately, without waiting for a clock; data_ready = 1.
   - Next word 4'b1011 serializes fully from its MSB.
5. data_valid high while data_ready low (hold full):
   - The word is not captured and no overwrite occurs.
   - It is captured on the first edge after data_ready rises and serializes in order.
6. With SEQ_SERIALIZER_LSB_FIRST_EN defined, word 4'b1101 -> seq = 1,0,1,1, same latency and underrun timing.
